// File: rtl/mem_access_unit.sv
// Memory access stage: decodes load/store requests, drives a req/ack bus
// with a bounded wait, and formats load data for writeback.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_d;
  logic [7:0]            cnt, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic                  req_d, we_d, vout_d;
  logic [DATA_WIDTH-1:0] maddr_d, wdata_d, res_d;
  logic [3:0]            be_d;
  logic [1:0]            err_d;

  logic                  illegal, misal;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] ld_data;

  assign stall = (state == BUSY);

  // Request legality, alignment and store lane formatting.
  always_comb begin
    illegal = 1'b0;
    if (MemRead && MemWrite)
      illegal = 1'b1;
    else if (MemRead)
      illegal = !(Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (MemWrite)
      illegal = !(Funct3 inside {3'b000, 3'b001, 3'b010});
    misal = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
            ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    st_be    = 4'b1111;
    st_wdata = WriteData;
    unique case (Funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALUResult[1:0];
        st_wdata = {4{WriteData[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << ALUResult[1:0];
        st_wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   lane_b = mem_rdata[7:0];
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_data = {24'b0, lane_b};
      3'b101:  ld_data = {16'b0, lane_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next-state and registered output values.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    f3_d    = f3_q;
    req_d   = mem_req;
    we_d    = mem_we;
    maddr_d = mem_addr;
    wdata_d = mem_wdata;
    be_d    = mem_be;
    vout_d  = 1'b0;
    res_d   = result;
    err_d   = err;
    unique case (state)
      IDLE: begin
        if (valid_in) begin
          vout_d = 1'b1;
          res_d  = ALUResult;
          err_d  = 2'b00;
          if (!MemRead && !MemWrite) begin
            err_d = 2'b00;
          end else if (illegal) begin
            err_d = 2'b11;
          end else if (misal) begin
            err_d = 2'b01;
          end else begin
            vout_d  = 1'b0;
            state_d = BUSY;
            cnt_d   = 8'd0;
            addr_d  = ALUResult;
            f3_d    = Funct3;
            req_d   = 1'b1;
            we_d    = MemWrite;
            maddr_d = {ALUResult[31:2], 2'b00};
            be_d    = MemWrite ? st_be : 4'b1111;
            wdata_d = MemWrite ? st_wdata : '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          vout_d  = 1'b1;
          err_d   = 2'b00;
          res_d   = mem_we ? addr_q : ld_data;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          vout_d  = 1'b1;
          err_d   = 2'b10;
          res_d   = addr_q;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      valid_out <= 1'b0;
      result    <= '0;
      err       <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
      valid_out <= vout_d;
      result    <= res_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors covering
// pass-through, faults, loads, stores, timeout and reset abort.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] ALUResult, WriteData;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, valid_out;
  logic [31:0] result;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  int n;

  mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .valid_out(valid_out),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_in  = 1'b1;
    MemRead   = rd;
    MemWrite  = wr;
    Funct3    = f3;
    ALUResult = a;
    WriteData = wd;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; ALUResult = '0; WriteData = '0;
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_vout", 32'(valid_out), 0);
    chk("rst_res", result, 0);
    chk("rst_stall", 32'(stall), 0);
    reset = 1'b1;
    tick();

    // non-memory pass-through
    issue(0, 0, 3'b000, 32'h2A, 0);
    chk("pt_vout", 32'(valid_out), 1);
    chk("pt_res", result, 32'h2A);
    chk("pt_err", 32'(err), 0);
    chk("pt_req", 32'(mem_req), 0);
    tick();
    chk("pt_vout_drop", 32'(valid_out), 0);
    chk("pt_res_hold", result, 32'h2A);

    // misaligned LW
    issue(1, 0, 3'b010, 32'h6, 0);
    chk("mis_vout", 32'(valid_out), 1);
    chk("mis_err", 32'(err), 1);
    chk("mis_res", result, 32'h6);
    chk("mis_req", 32'(mem_req), 0);
    tick();

    // illegal: both read and write, then store with BU code
    issue(1, 1, 3'b010, 32'h10, 0);
    chk("ill_rw_err", 32'(err), 3);
    chk("ill_rw_req", 32'(mem_req), 0);
    issue(0, 1, 3'b100, 32'h20, 0);
    chk("ill_st_err", 32'(err), 3);
    chk("ill_st_res", result, 32'h20);
    tick();

    // LB 0x1003, ack on second busy cycle
    issue(1, 0, 3'b000, 32'h1003, 0);
    n = 0;
    if (stall) n++;
    chk("lb_req", 32'(mem_req), 1);
    chk("lb_be", 32'(mem_be), 32'hF);
    chk("lb_we", 32'(mem_we), 0);
    chk("lb_addr", mem_addr, 32'h1000);
    chk("lb_vout_busy", 32'(valid_out), 0);
    tick();
    if (stall) n++;
    ack_with(32'h8000_0000);
    if (stall) n++;
    chk("lb_stall_cycles", 32'(n), 2);
    chk("lb_vout", 32'(valid_out), 1);
    chk("lb_res", result, 32'hFFFF_FF80);
    chk("lb_err", 32'(err), 0);
    chk("lb_req_drop", 32'(mem_req), 0);
    tick();
    chk("lb_vout_once", 32'(valid_out), 0);

    // SH 0x2002
    issue(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(mem_we), 1);
    chk("sh_addr", mem_addr, 32'h2000);
    ack_with(32'h0);
    chk("sh_res", result, 32'h2002);
    chk("sh_err", 32'(err), 0);

    // SB 0x3001, SW 0x3004
    issue(0, 1, 3'b000, 32'h3001, 32'hAA55);
    chk("sb_be", 32'(mem_be), 32'h2);
    chk("sb_wdata", mem_wdata, 32'h5555_5555);
    ack_with(32'h0);
    issue(0, 1, 3'b010, 32'h3004, 32'hCAFE_F00D);
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    ack_with(32'h0);

    // LBU, LH, LHU lane selection
    issue(1, 0, 3'b100, 32'h3002, 0);
    ack_with(32'h00AB_0000);
    chk("lbu_res", result, 32'hAB);
    issue(1, 0, 3'b001, 32'h3002, 0);
    ack_with(32'h8001_0000);
    chk("lh_res", result, 32'hFFFF_8001);
    issue(1, 0, 3'b101, 32'h3000, 0);
    ack_with(32'h1234_9876);
    chk("lhu_res", result, 32'h9876);

    // LHU 0x100 timeout
    issue(1, 0, 3'b101, 32'h100, 0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 16);
    chk("to_vout", 32'(valid_out), 1);
    chk("to_err", 32'(err), 2);
    chk("to_res", result, 32'h100);
    chk("to_stall", 32'(stall), 0);
    tick();

    // ack on the timeout cycle wins
    issue(1, 0, 3'b010, 32'h40, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("pri_busy", 32'(stall), 1);
    ack_with(32'hDEAD_BEEF);
    chk("pri_err", 32'(err), 0);
    chk("pri_res", result, 32'hDEAD_BEEF);
    tick();

    // reset during busy, then late ack
    issue(1, 0, 3'b010, 32'h80, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rb_req", 32'(mem_req), 0);
    chk("rb_addr", mem_addr, 0);
    chk("rb_res", result, 0);
    chk("rb_stall", 32'(stall), 0);
    ack_with(32'h1111_1111);
    chk("rb_vout", 32'(valid_out), 0);
    chk("rb_res_after", result, 0);
    chk("rb_stall_after", 32'(stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
